// File: rtl/rv_dmem_resp_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface rv_dmem_resp_if;
  logic        req_i;
  logic        we_i;
  logic [63:0] addr_i;
  logic [2:0]  size_i;
  logic [63:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output req_i, we_i, addr_i, size_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, size_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );
endinterface

// File: rtl/rv_dmem_resp.sv
// RV64 data-memory responder: one request at a time, WAIT_CYC wait states, then a one-cycle rvalid_o pulse.
// gnt_o is high only in IDLE; requests presented while busy are ignored.
module rv_dmem_resp #(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 1
) (
  input logic           clk,
  input logic           rstn,
  rv_dmem_resp_if.slave bus
);
  localparam int         DEPTH     = 2 ** (ADDR_W - 3);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [DEPTH];

  logic              eff_we;
  logic [63:0]       eff_addr;
  logic [2:0]        eff_size;
  logic [63:0]       eff_wdata;
  logic [ADDR_W-4:0] idx;
  logic [5:0]        sh;
  logic [63:0]       rd_word, load_sh, load_val, size_mask, bit_mask, wr_word;
  logic              acc_err, do_access, mem_we;

  // With WAIT_CYC=0 the access happens on the accept edge, before the latches hold anything.
  always_comb begin
    if (state_q == S_IDLE) begin
      eff_we    = bus.we_i;
      eff_addr  = bus.addr_i;
      eff_size  = bus.size_i;
      eff_wdata = bus.wdata_i;
    end else begin
      eff_we    = we_q;
      eff_addr  = addr_q;
      eff_size  = size_q;
      eff_wdata = wdata_q;
    end
  end

  always_comb begin
    idx     = eff_addr[ADDR_W-1:3];
    sh      = {eff_addr[2:0], 3'b000};
    rd_word = mem_q[idx];
    load_sh = rd_word >> sh;

    acc_err = 1'b0;
    if (eff_size == 3'b111)                                 acc_err = 1'b1;
    if (eff_size[1:0] == 2'b01 && eff_addr[0])              acc_err = 1'b1;
    if (eff_size[1:0] == 2'b10 && eff_addr[1:0] != 2'b00)   acc_err = 1'b1;
    if (eff_size == 3'b011 && eff_addr[2:0] != 3'b000)      acc_err = 1'b1;
    if (eff_addr[63:ADDR_W] != '0)                          acc_err = 1'b1;

    case (eff_size)
      3'b000:  load_val = {{56{load_sh[7]}},  load_sh[7:0]};
      3'b001:  load_val = {{48{load_sh[15]}}, load_sh[15:0]};
      3'b010:  load_val = {{32{load_sh[31]}}, load_sh[31:0]};
      3'b011:  load_val = load_sh;
      3'b100:  load_val = {56'd0, load_sh[7:0]};
      3'b101:  load_val = {48'd0, load_sh[15:0]};
      3'b110:  load_val = {32'd0, load_sh[31:0]};
      default: load_val = '0;
    endcase

    case (eff_size[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
    bit_mask = size_mask << sh;
    wr_word  = (rd_word & ~bit_mask) | ((eff_wdata << sh) & bit_mask);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    rvalid_d  = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
    do_access = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          addr_d  = bus.addr_i;
          size_d  = bus.size_i;
          wdata_d = bus.wdata_i;
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT != 4'd0) begin
            state_d = S_WAIT;
          end else begin
            state_d   = S_RESP;
            do_access = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = S_RESP;
          do_access = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (do_access) begin
      rvalid_d = 1'b1;
      err_d    = acc_err;
      rdata_d  = (acc_err || eff_we) ? 64'd0 : load_val;
    end
    mem_we = do_access && eff_we && !acc_err && rstn;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array contents survive reset; only committed stores modify it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  assign bus.gnt_o    = (state_q == S_IDLE);
  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;
endmodule
